uart_rx_loader: RTL and testbench

Serial receive front-end feeding main_control. It receives 8N1 UART bytes on `rx` and writes them sequentially into data memory from address 0. After NUM_BYTES bytes are written it raises `end_receiving`, which moves main_control from receive to process. It is the stage directly upstream of the controller's receive phase.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_loader_if.sv | 13 +
 rtl/baud_tick_gen.sv | 27 ++
 rtl/uart_rx_loader.sv | 153 +++++++++++++++
 tb/tb_uart_rx_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Constants and FSM state encoding shared by the UART receive loader and the
// future transmit unloader.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int BAUD_DIV_DEF   = 54;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    ERR   = 3'd4,
    DONE  = 3'd5
  } rx_state_t;

endpackage

// File: rtl/uart_rx_loader_if.sv
// Data-memory write bus driven by the UART receive loader.
interface uart_rx_loader_if #(
  parameter int ADDR_W = 16
) ();

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;

  modport master (output mem_we, mem_addr, mem_wdata);
  modport slave  (input  mem_we, mem_addr, mem_wdata);

endinterface

// File: rtl/baud_tick_gen.sv
// Free-running divider: one-cycle tick every BAUD_DIV clk cycles.
module baud_tick_gen #(
  parameter int BAUD_DIV = 54
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/uart_rx_loader.sv
// 8N1 UART receiver that stores NUM_BYTES bytes sequentially into data memory
// from address 0, then signals end_receiving until reset.
module uart_rx_loader
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = BAUD_DIV_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int ADDR_W     = 16,
  parameter int NUM_BYTES  = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx,
  input  logic                     rx_en,
  uart_rx_loader_if.master         mem,
  output logic                     end_receiving,
  output logic                     frame_err
);

  localparam int TW   = $clog2(OVERSAMPLE);
  localparam int CNTW = ADDR_W + 1;
  localparam logic [TW-1:0]   HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]   LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [CNTW-1:0] NUM       = CNTW'(NUM_BYTES);

  logic tick;

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  logic              rx_meta_reg;
  logic              rx_s_reg;
  rx_state_t         state_reg;
  logic [TW-1:0]     tcnt_reg;
  logic [2:0]        bit_idx_reg;
  logic [7:0]        shift_reg;
  logic [CNTW-1:0]   cnt_reg;
  logic [CNTW-1:0]   cnt_inc;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        wdata_reg;
  logic              end_reg;
  logic              ferr_reg;

  assign cnt_inc = cnt_reg + 1'b1;

  // Two-flop synchroniser; rx is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      tcnt_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      end_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      we_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (rx_en && !rx_s_reg) begin
            state_reg <= START;
            tcnt_reg  <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (tcnt_reg == HALF_TICK) begin
              tcnt_reg <= '0;
              if (!rx_s_reg) begin
                state_reg   <= DATA;
                bit_idx_reg <= '0;
              end else begin
                state_reg <= IDLE;
              end
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tcnt_reg == LAST_TICK) begin
              tcnt_reg  <= '0;
              shift_reg <= {rx_s_reg, shift_reg[7:1]};
              if (bit_idx_reg == 3'd7) begin
                state_reg <= STOP;
              end else begin
                bit_idx_reg <= bit_idx_reg + 1'b1;
              end
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
            if (tcnt_reg == LAST_TICK) begin
              tcnt_reg <= '0;
              if (rx_s_reg) begin
                we_reg    <= 1'b1;
                addr_reg  <= cnt_reg[ADDR_W-1:0];
                wdata_reg <= shift_reg;
                cnt_reg   <= cnt_inc;
                state_reg <= (cnt_inc == NUM) ? DONE : IDLE;
              end else begin
                // Bad stop bit: drop the byte and wait out any break.
                ferr_reg  <= 1'b1;
                state_reg <= ERR;
              end
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end
        ERR: begin
          if (rx_s_reg) begin
            state_reg <= IDLE;
          end
        end
        DONE: begin
          end_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign mem.mem_we     = we_reg;
  assign mem.mem_addr   = addr_reg;
  assign mem.mem_wdata  = wdata_reg;
  assign end_receiving  = end_reg;
  assign frame_err      = ferr_reg;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Scoreboard bench for uart_rx_loader: expected writes are queued as frames
// are driven and matched against each mem_we pulse.
module tb_uart_rx_loader;

  localparam int BAUD_DIV   = 2;
  localparam int OVERSAMPLE = 16;
  localparam int ADDR_W     = 4;
  localparam int NUM_BYTES  = 4;
  localparam int BIT_CLK    = BAUD_DIV * OVERSAMPLE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic rx_en = 1'b0;
  logic end_receiving;
  logic frame_err;

  uart_rx_loader_if #(.ADDR_W(ADDR_W)) mem_bus ();

  uart_rx_loader #(
    .BAUD_DIV   (BAUD_DIV),
    .OVERSAMPLE (OVERSAMPLE),
    .ADDR_W     (ADDR_W),
    .NUM_BYTES  (NUM_BYTES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .rx_en         (rx_en),
    .mem           (mem_bus.master),
    .end_receiving (end_receiving),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_writes = 0;
  logic [ADDR_W+7:0] sb_q[$];
  logic              prev_we = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Write monitor: pop the scoreboard on every mem_we pulse.
  always @(negedge clk) begin
    logic [ADDR_W+7:0] exp_w;
    if (!rst) begin
      if (mem_bus.mem_we) begin
        n_writes++;
        $display("WR addr=%0d data=0x%02h end=%0b", mem_bus.mem_addr, mem_bus.mem_wdata, end_receiving);
        check("we_single_cycle", {31'd0, prev_we}, 32'd0);
        check("end_during_we", {31'd0, end_receiving}, 32'd0);
        if (sb_q.size() == 0) begin
          check("write_without_expect", sb_q.size(), 32'd1);
        end else begin
          exp_w = sb_q.pop_front();
          check("mem_addr", {28'd0, mem_bus.mem_addr}, {28'd0, exp_w[ADDR_W+7:8]});
          check("mem_wdata", {24'd0, mem_bus.mem_wdata}, {24'd0, exp_w[7:0]});
        end
      end
      if (prev_we && prev_addr == ADDR_W'(NUM_BYTES - 1)) begin
        check("end_after_last", {31'd0, end_receiving}, 32'd1);
      end
    end
    prev_we   <= mem_bus.mem_we;
    prev_addr <= mem_bus.mem_addr;
  end

  task automatic drive_bit(input logic v);
    @(negedge clk);
    rx = v;
    repeat (BIT_CLK - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    sb_q.push_back({a, d});
  endtask

  task automatic idle_bits(input int n);
    @(negedge clk);
    rx = 1'b1;
    repeat (n * BIT_CLK) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},   {31'd0, mem_bus.mem_we}, 32'd0);
    check({tag, "_addr"}, {28'd0, mem_bus.mem_addr}, 32'd0);
    check({tag, "_data"}, {24'd0, mem_bus.mem_wdata}, 32'd0);
    check({tag, "_end"},  {31'd0, end_receiving}, 32'd0);
    check({tag, "_ferr"}, {31'd0, frame_err}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;

    // 1: reset, then quiet line with receiver disabled
    do_reset();
    check_reset_outputs("rst");
    w0 = n_writes;
    repeat (200) @(negedge clk);
    check("rst_no_write", n_writes - w0, 32'd0);

    // 2: single byte
    do_reset();
    rx_en = 1'b1;
    w0 = n_writes;
    expect_write(4'd0, 8'hA5);
    send_frame(8'hA5, 1'b1);
    idle_bits(1);
    check("t2_pending", sb_q.size(), 32'd0);
    check("t2_writes", n_writes - w0, 32'd1);
    check("t2_end", {31'd0, end_receiving}, 32'd0);

    // 3: fill memory back-to-back, then an extra byte must be ignored
    do_reset();
    begin
      logic [7:0] seq [4];
      seq = '{8'h01, 8'h02, 8'h03, 8'hFF};
      for (int i = 0; i < 4; i++) begin
        expect_write(ADDR_W'(i), seq[i]);
        send_frame(seq[i], 1'b1);
      end
    end
    idle_bits(1);
    check("t3_pending", sb_q.size(), 32'd0);
    check("t3_end", {31'd0, end_receiving}, 32'd1);
    w0 = n_writes;
    send_frame(8'h55, 1'b1);
    idle_bits(1);
    check("t3_extra_writes", n_writes - w0, 32'd0);
    check("t3_end_held", {31'd0, end_receiving}, 32'd1);

    // 4: short glitch must not start a frame
    do_reset();
    w0 = n_writes;
    @(negedge clk);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("t4_glitch_writes", n_writes - w0, 32'd0);
    expect_write(4'd0, 8'h3C);
    send_frame(8'h3C, 1'b1);
    idle_bits(1);
    check("t4_pending", sb_q.size(), 32'd0);

    // 5: bad stop bit followed by a break
    do_reset();
    w0 = n_writes;
    send_frame(8'h77, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (2 * BIT_CLK) @(negedge clk);
    idle_bits(1);
    check("t5_ferr", {31'd0, frame_err}, 32'd1);
    check("t5_no_write", n_writes - w0, 32'd0);
    expect_write(4'd0, 8'h12);
    send_frame(8'h12, 1'b1);
    idle_bits(1);
    check("t5_pending", sb_q.size(), 32'd0);
    check("t5_ferr_sticky", {31'd0, frame_err}, 32'd1);

    // 6: reset in the middle of a frame
    do_reset();
    expect_write(4'd0, 8'h11);
    send_frame(8'h11, 1'b1);
    expect_write(4'd1, 8'h22);
    send_frame(8'h22, 1'b1);
    check("t6_pre_pending", sb_q.size(), 32'd0);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b0);
    @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("t6_rst");
    repeat (4 * BIT_CLK) @(negedge clk);
    expect_write(4'd0, 8'h9A);
    send_frame(8'h9A, 1'b1);
    idle_bits(1);
    check("t6_pending", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
